// File: rtl/sddac_interp.sv
// sddac_interp -- linear interpolator feeding the sigma-delta DAC.
//
// Accepts low-rate signed samples over a valid/ready handshake and produces
// one linearly interpolated 16-bit signed sample every clock. Each input
// sample becomes the endpoint of a segment R = 2^OSR_LOG2 clocks long.
// A one-deep skid register (nxt) decouples upstream from the segment timing.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   in_sample    signed input sample (16b)
//   in_valid     in_sample valid this cycle
//   in_ready     block can accept a sample this cycle (= !nxt_full)
//   sig_out      interpolated signed sample (16b), drives sddac sig
//   sample_tick  one-cycle pulse in the cycle after each segment wrap
//   underrun     one-cycle pulse after a wrap that found nxt empty
module sddac_interp #(
  parameter int OSR_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_sample,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] sig_out,
  output logic        sample_tick,
  output logic        underrun
);

  localparam int AW = 16 + OSR_LOG2;
  localparam logic [OSR_LOG2-1:0] PHASE_LAST = '1;

  logic signed [15:0]       cur_reg, cur_next;
  logic signed [15:0]       tgt_reg, tgt_next;
  logic signed [15:0]       nxt_reg, nxt_next;
  logic                     nxt_full_reg, nxt_full_next;
  logic [OSR_LOG2-1:0]      phase_reg, phase_next;
  logic signed [AW-1:0]     acc_reg, acc_next;
  logic                     tick_reg, tick_next;
  logic                     underrun_reg, underrun_next;

  logic signed [16:0]       delta;
  logic signed [AW-1:0]     delta_ext;
  logic                     wrap;
  logic                     accept;

  // The segment slope is carried implicitly by cur/tgt: after a wrap that
  // consumes nxt this is nxt - old tgt, and after an underrun wrap cur == tgt
  // so the slope is zero and the output holds flat.
  assign delta     = 17'(tgt_reg) - 17'(cur_reg);
  assign delta_ext = AW'(delta);

  assign wrap   = (phase_reg == PHASE_LAST);
  assign accept = in_valid && !nxt_full_reg;

  assign in_ready    = !nxt_full_reg;
  assign sig_out     = acc_reg[AW-1:OSR_LOG2];
  assign sample_tick = tick_reg;
  assign underrun    = underrun_reg;

  always_comb begin
    cur_next      = cur_reg;
    tgt_next      = tgt_reg;
    nxt_next      = nxt_reg;
    nxt_full_next = nxt_full_reg;
    phase_next    = phase_reg + OSR_LOG2'(1);
    acc_next      = acc_reg + delta_ext;
    tick_next     = 1'b0;
    underrun_next = 1'b0;

    if (wrap) begin
      phase_next = '0;
      // Reload from the endpoint instead of accumulating, so every segment
      // starts exactly on its sample with no drift carried over.
      acc_next   = {tgt_reg, {OSR_LOG2{1'b0}}};
      cur_next   = tgt_reg;
      tick_next  = 1'b1;
      if (nxt_full_reg) begin
        tgt_next      = nxt_reg;
        nxt_full_next = 1'b0;
      end else begin
        underrun_next = 1'b1;
      end
    end

    // in_ready is registered, so a wrap that empties nxt cannot also accept;
    // an accept on an underrun wrap lands in nxt for the following segment.
    if (accept) begin
      nxt_next      = in_sample;
      nxt_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_reg      <= '0;
      tgt_reg      <= '0;
      nxt_reg      <= '0;
      nxt_full_reg <= 1'b0;
      phase_reg    <= '0;
      acc_reg      <= '0;
      tick_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      cur_reg      <= cur_next;
      tgt_reg      <= tgt_next;
      nxt_reg      <= nxt_next;
      nxt_full_reg <= nxt_full_next;
      phase_reg    <= phase_next;
      acc_reg      <= acc_next;
      tick_reg     <= tick_next;
      underrun_reg <= underrun_next;
    end
  end

endmodule

// File: tb/tb_sddac_interp.sv
// Testbench for sddac_interp at OSR_LOG2 = 2 (R = 4).
// Directed vector table for the reset/ramp/floor-rounding sequence, hand
// sequences for full-scale swing, underrun, back-to-back hold-off and
// mid-segment reset, then randomized traffic. A segment-level reference
// model (endpoints plus position within segment) predicts every output.
module tb_sddac_interp;

  localparam int K = 2;
  localparam int R = 1 << K;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_sample;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sig_out;
  logic        sample_tick;
  logic        underrun;

  sddac_interp #(.OSR_LOG2(K)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_sample  (in_sample),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sig_out    (sig_out),
    .sample_tick(sample_tick),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the segment runs from m_cur to m_tgt, m_k clocks in.
  int   m_cur, m_tgt, m_nxt, m_k;
  bit   m_full, m_tick, m_under;
  bit   last_accepted;

  typedef struct {
    logic        rst_n;
    logic        v;
    int          s;
    int          exp_sig;
    logic        exp_ready;
    logic        exp_tick;
    logic        exp_under;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic r, logic v, int s, int es, logic er, logic et, logic eu);
    vec_t t;
    t.rst_n = r; t.v = v; t.s = s; t.exp_sig = es;
    t.exp_ready = er; t.exp_tick = et; t.exp_under = eu;
    return t;
  endfunction

  function automatic int fdiv(int a, int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int model_sig();
    return m_cur + fdiv(m_k * (m_tgt - m_cur), R);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs presented at this edge,
  // then compare all outputs 1 time unit after the edge.
  task automatic step();
    bit acc;
    acc = rst_n && in_valid && !m_full;
    @(posedge clk);
    if (!rst_n) begin
      m_cur = 0; m_tgt = 0; m_nxt = 0; m_k = 0;
      m_full = 0; m_tick = 0; m_under = 0;
    end else begin
      if (m_k == R - 1) begin
        m_k = 0; m_tick = 1; m_under = !m_full; m_cur = m_tgt;
        if (m_full) begin
          m_tgt = m_nxt; m_full = 0;
        end
      end else begin
        m_k++; m_tick = 0; m_under = 0;
      end
      if (acc) begin
        m_nxt = $signed(in_sample); m_full = 1;
      end
    end
    last_accepted = acc;
    #1;
    chk("sig_out", int'($signed(sig_out)), model_sig());
    chk("in_ready", int'(in_ready), int'(!m_full));
    chk("sample_tick", int'(sample_tick), int'(m_tick));
    chk("underrun", int'(underrun), int'(m_under));
  endtask

  task automatic offer(int s);
    bit done;
    done = 0;
    in_valid  = 1'b1;
    in_sample = 16'(s);
    for (int i = 0; i < 3 * R && !done; i++) begin
      step();
      done = last_accepted;
    end
    in_valid = 1'b0;
    if (!done) chk("offer_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ucnt_dut, ucnt_mod, wait_cnt;

    rst_n = 1'b0; in_valid = 1'b0; in_sample = '0;
    m_cur = 0; m_tgt = 0; m_nxt = 0; m_k = 0;
    m_full = 0; m_tick = 0; m_under = 0; last_accepted = 0;

    //          rst v  sample  sig    rdy tick under
    tbl[0]  = mk(0, 0, 0,      0,     1,  0,   0);
    tbl[1]  = mk(0, 0, 0,      0,     1,  0,   0);
    tbl[2]  = mk(1, 1, 400,    0,     0,  0,   0);
    tbl[3]  = mk(1, 0, 0,      0,     0,  0,   0);
    tbl[4]  = mk(1, 0, 0,      0,     0,  0,   0);
    tbl[5]  = mk(1, 0, 0,      0,     1,  1,   0);
    tbl[6]  = mk(1, 1, -401,   100,   0,  0,   0);
    tbl[7]  = mk(1, 0, 0,      200,   0,  0,   0);
    tbl[8]  = mk(1, 0, 0,      300,   0,  0,   0);
    tbl[9]  = mk(1, 0, 0,      400,   1,  1,   0);
    tbl[10] = mk(1, 0, 0,      199,   1,  0,   0);
    tbl[11] = mk(1, 0, 0,      -1,    1,  0,   0);
    tbl[12] = mk(1, 0, 0,      -201,  1,  0,   0);
    tbl[13] = mk(1, 0, 0,      -401,  1,  1,   1);
    tbl[14] = mk(1, 0, 0,      -401,  1,  0,   0);

    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      rst_n = tbl[i].rst_n; in_valid = tbl[i].v; in_sample = 16'(tbl[i].s);
      step();
      chk($sformatf("tbl%0d_sig", i), int'($signed(sig_out)), tbl[i].exp_sig);
      chk($sformatf("tbl%0d_ready", i), int'(in_ready), int'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_tick", i), int'(sample_tick), int'(tbl[i].exp_tick));
      chk($sformatf("tbl%0d_under", i), int'(underrun), int'(tbl[i].exp_under));
      $display("vec %0d: sig=%0d ready=%0b tick=%0b under=%0b", i,
               $signed(sig_out), in_ready, sample_tick, underrun);
    end
    in_valid = 1'b0;

    // Full-scale swings in both directions.
    offer(32767); offer(-32768); offer(32767); offer(-32768);
    for (int i = 0; i < 2 * R; i++) step();
    chk("fullscale_end", int'($signed(sig_out)), -32768);
    $display("fullscale: sig=%0d", $signed(sig_out));

    // Starve the block: underrun once per wrap, output flat.
    ucnt_dut = 0; ucnt_mod = 0;
    for (int i = 0; i < 5 * R; i++) begin
      step();
      ucnt_dut += int'(underrun);
      ucnt_mod += int'(m_under);
    end
    chk("underrun_count", ucnt_dut, ucnt_mod);
    chk("underrun_flat", int'($signed(sig_out)), -32768);
    $display("idle: underruns=%0d", ucnt_dut);
    offer(1000);
    for (int i = 0; i < 3 * R; i++) step();
    chk("resume_end", int'($signed(sig_out)), 1000);
    $display("resume: sig=%0d", $signed(sig_out));

    // Back-to-back: the second sample waits for the wrap to consume the first.
    offer(-5000);
    in_valid = 1'b1; in_sample = 16'(7000);
    wait_cnt = 0;
    while (m_full && wait_cnt < 3 * R) begin
      step(); wait_cnt++;
      if (m_full) chk("b2b_holdoff", int'(in_ready), 0);
    end
    offer(7000);
    wait_cnt = 0;
    while (m_k != 2 && wait_cnt < 2 * R) begin
      step(); wait_cnt++;
    end
    chk("phase2_reached", m_k, 2);
    rst_n = 1'b0;
    step();
    chk("midrst_sig", int'($signed(sig_out)), 0);
    chk("midrst_ready", int'(in_ready), 1);
    chk("midrst_tick", int'(sample_tick), 0);
    chk("midrst_under", int'(underrun), 0);
    $display("midreset: sig=%0d ready=%0b", $signed(sig_out), in_ready);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * R; i++) begin
      step();
      chk("post_rst_flat", int'($signed(sig_out)), 0);
    end

    // Randomized traffic; samples are held while not accepted.
    last_accepted = 1;
    for (int i = 0; i < 3000; i++) begin
      if (!in_valid || last_accepted) begin
        in_valid = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 85 : 20));
        case ($urandom_range(0, 7))
          0:       in_sample = 16'h7fff;
          1:       in_sample = 16'h8000;
          default: in_sample = 16'($urandom);
        endcase
      end
      rst_n = ($urandom_range(0, 499) != 0);
      if (!rst_n) in_valid = 1'b0;
      step();
      if (i % 500 == 0)
        $display("rand %0d: sig=%0d ready=%0b tick=%0b under=%0b", i,
                 $signed(sig_out), in_ready, sample_tick, underrun);
    end
    rst_n = 1'b1; in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sddac_interp.md
SDDAC_INTERP -- requirements
Module: sddac_interp

Upstream of sddac: accepts low-rate samples over a valid/ready handshake and drives a linearly interpolated 16-bit signed sample to sddac's sig input every clock.

Interface
REQ-001 Parameter OSR_LOG2, default 6, log2 of interpolation ratio R = 2^OSR_LOG2; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in_sample  input  16  signed input sample.
REQ-005 in_valid  input  1  in_sample is valid this cycle.
REQ-006 in_ready  output  1  block can accept a sample this cycle.
REQ-007 sig_out  output  16  signed interpolated sample; connects to sddac sig.
REQ-008 sample_tick  output  1  one-cycle pulse on segment boundary (wrap).
REQ-009 underrun  output  1  one-cycle pulse when a wrap finds no buffered sample.

Function
REQ-010 State: cur (16b signed), tgt (16b signed), nxt (16b signed), nxt_full (1b), phase (OSR_LOG2 bits, unsigned), delta (17b signed, = tgt - cur), acc (16+OSR_LOG2 bits, signed).
REQ-011 in_ready SHALL equal !nxt_full (combinational from register); no accept on the same cycle a wrap empties nxt.
REQ-012 Handshake: in_valid && in_ready at a rising edge loads nxt <= in_sample, nxt_full <= 1; upstream holds in_sample while in_valid && !in_ready.
REQ-013 sig_out SHALL equal acc arithmetically shifted right by OSR_LOG2 (floor), i.e. acc[OSR_LOG2+15:OSR_LOG2].
REQ-014 Non-wrap cycle (phase != R-1): phase <= phase+1; acc <= acc + sign-extended delta.
REQ-015 Wrap cycle (phase == R-1): phase <= 0; acc <= tgt << OSR_LOG2 (explicit reload, no accumulated drift); cur <= tgt.
REQ-016 On wrap with nxt_full=1: tgt <= nxt, nxt_full <= 0, delta <= nxt - tgt.
REQ-017 On wrap with nxt_full=0: tgt unchanged, delta <= 0, underrun = 1 for the following cycle (output holds flat).
REQ-018 A sample accepted on a wrap cycle with nxt_full=0 goes to nxt only; underrun is still flagged.
REQ-019 sample_tick = 1 for exactly the cycle after each wrap (phase == 0 and not the first cycle after reset).
REQ-020 At phase 0 sig_out SHALL equal cur exactly; within a segment sig_out lies between cur and tgt inclusive.
REQ-021 delta is 17 bits so full-scale swing (32767 to -32768, delta -65535) never overflows; acc never leaves the range [-32768, 32767] << OSR_LOG2.
REQ-022 Phase counter runs free from reset; R clocks per input sample; sustained throughput one sample per R clocks.
REQ-023 Latency: a sample accepted into empty nxt reaches sig_out as endpoint after at most 2R clocks (remainder of current segment + one full segment).

Reset
REQ-024 While rst_n = 0 at a rising edge: cur, tgt, nxt, delta, acc, phase <= 0; nxt_full <= 0.
REQ-025 Post-reset outputs: sig_out = 0, in_ready = 1, sample_tick = 0, underrun = 0.
REQ-026 Reset asserted mid-segment discards the segment and any buffered sample; no residual output after release.

Verification (OSR_LOG2 = 2, R = 4)
REQ-027 Hold rst_n=0 two cycles -> sig_out=0, in_ready=1, sample_tick=0, underrun=0; release -> sig_out 0 for phases 0..3.
REQ-028 Offer 400 immediately after release -> accepted, in_ready=0; first segment outputs 0,0,0,0; next segment 0,100,200,300; then 400 at following phase 0.
REQ-029 Segment 400 -> -401 -> sig_out 400, 199, -1, -201, then -401 (floor rounding on negatives).
REQ-030 Segment 32767 -> -32768 and back -> endpoints exact, monotone ramps, no wrap-around glitch.
REQ-031 Stop supplying samples -> underrun pulses once per wrap, sample_tick still pulses, sig_out flat at last tgt; resume -> underrun stops.
REQ-032 Two samples back-to-back -> second held off (in_ready=0) until the wrap consumes the first; assert rst_n=0 at phase 2 -> next cycle all state zero, in_ready=1.
